// File: rtl/adder_test_port_if.sv
// Test-port bundle between the DFT controller (master) and the adder/mux side (slave).
// Carries the scan handshake, the mux drive signals and the adder response.
interface adder_test_port_if #(
   parameter int N = 16
);
   logic         start;
   logic         scan_in;
   logic         scan_out;
   logic         busy;
   logic         done;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         sel;
   logic [N-1:0] sum;
   logic         cout;
   logic [N:0]   misr_sig;

   modport master (
      input  start, scan_in, sum, cout,
      output a, b, cin, sel, scan_out, busy, done, misr_sig
   );

   modport slave (
      output start, scan_in, sum, cout,
      input  a, b, cin, sel, scan_out, busy, done, misr_sig
   );
endinterface

// File: rtl/adder_test_port.sv
// DFT test-access controller for an N-bit ripple adder: scan pattern in, drive mux, capture, scan out.
// Optional MISR signature compaction of every captured response when ADDER_TEST_MISR_EN is defined.
module adder_test_port #(
   parameter int N      = 16,
   parameter int SETTLE = 1
) (
   input logic                clk,
   input logic                rst_n,
   adder_test_port_if.master  tp
);

   localparam int CW = $clog2(2*N+2);
   // SETTLE must fit the shared per-state counter (1 .. 2N+2)
   localparam logic [CW-1:0] SHIFT_IN_LAST  = CW'(2*N);
   localparam logic [CW-1:0] APPLY_LAST     = CW'(SETTLE-1);
   localparam logic [CW-1:0] SHIFT_OUT_LAST = CW'(N);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SHIFT_IN  = 3'd1,
      APPLY     = 3'd2,
      CAPTURE   = 3'd3,
      SHIFT_OUT = 3'd4
   } state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [2*N-1:0]   pat_reg, pat_next;
   logic [2*N:0]     pat_full;
   logic [N:0]       resp_reg, resp_next;
   logic [N-1:0]     a_reg, a_next;
   logic [N-1:0]     b_reg, b_next;
   logic             cin_reg, cin_next;
   logic             sel_reg, sel_next;
   logic             scan_out_reg, scan_out_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + 1'b1;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (tp.start) state_next = SHIFT_IN;
         end
         SHIFT_IN: begin
            if (cnt_reg == SHIFT_IN_LAST) begin
               state_next = APPLY;
               cnt_next   = '0;
            end
         end
         APPLY: begin
            if (cnt_reg == APPLY_LAST) begin
               state_next = CAPTURE;
               cnt_next   = '0;
            end
         end
         CAPTURE: begin
            state_next = SHIFT_OUT;
            cnt_next   = '0;
         end
         SHIFT_OUT: begin
            if (cnt_reg == SHIFT_OUT_LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // The final pattern bit is taken straight from scan_in on the load edge,
   // so only 2N bits ever need to be stored.
   assign pat_full = {tp.scan_in, pat_reg};

   // ---------------- output / datapath next values ----------------
   always_comb begin
      pat_next      = pat_reg;
      resp_next     = resp_reg;
      a_next        = a_reg;
      b_next        = b_reg;
      cin_next      = cin_reg;
      scan_out_next = 1'b0;
      sel_next      = (state_next == APPLY) || (state_next == CAPTURE);
      busy_next     = (state_next != IDLE);
      done_next     = (state_reg == SHIFT_OUT) && (state_next == IDLE);

      case (state_reg)
         SHIFT_IN: begin
            pat_next = {tp.scan_in, pat_reg[2*N-1:1]};
            if (state_next == APPLY) begin
               cin_next = pat_full[0];
               b_next   = pat_full[N:1];
               a_next   = pat_full[2*N:N+1];
            end
         end
         CAPTURE:   resp_next = {tp.cout, tp.sum};
         SHIFT_OUT: resp_next = {1'b0, resp_reg[N:1]};
         default:   ;
      endcase

      // Release the adder to the functional pins as soon as the response is held
      if (state_next == SHIFT_OUT) begin
         a_next        = '0;
         b_next        = '0;
         cin_next      = 1'b0;
         scan_out_next = resp_next[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_reg      <= '0;
         resp_reg     <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         cin_reg      <= 1'b0;
         sel_reg      <= 1'b0;
         scan_out_reg <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         pat_reg      <= pat_next;
         resp_reg     <= resp_next;
         a_reg        <= a_next;
         b_reg        <= b_next;
         cin_reg      <= cin_next;
         sel_reg      <= sel_next;
         scan_out_reg <= scan_out_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
      end
   end

   assign tp.a        = a_reg;
   assign tp.b        = b_reg;
   assign tp.cin      = cin_reg;
   assign tp.sel      = sel_reg;
   assign tp.scan_out = scan_out_reg;
   assign tp.busy     = busy_reg;
   assign tp.done     = done_reg;

`ifdef ADDER_TEST_MISR_EN
   logic [N:0] misr_reg, misr_next, capt;

   assign capt = {tp.cout, tp.sum};

   // Feedback from the top bit into bit 0, each other bit takes its lower neighbour
   generate
      for (genvar gi = 0; gi <= N; gi++) begin : g_misr
         if (gi == 0) begin : g_fb
            assign misr_next[gi] = misr_reg[N] ^ capt[gi];
         end else begin : g_sh
            assign misr_next[gi] = misr_reg[gi-1] ^ capt[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         misr_reg <= '0;
      else if (state_reg == CAPTURE)
         misr_reg <= misr_next;
   end

   assign tp.misr_sig = misr_reg;
`else
   assign tp.misr_sig = '0;
`endif

endmodule

// File: tb/tb_adder_test_port.sv
// Bench for adder_test_port: table vectors, hand corner sequences and random patterns
// checked against plain-arithmetic expectations; includes an adder/mux environment model.
module tb_adder_test_port;

   localparam int N        = 16;
   localparam int SETTLE   = 1;
   localparam int BUSY_LEN = 2*N+1 + SETTLE + 1 + N+1;
   localparam int SO_START = 2*N+1 + SETTLE + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   adder_test_port_if #(.N(N)) tp ();

   adder_test_port #(.N(N), .SETTLE(SETTLE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .tp    (tp)
   );

   // Environment: 2:1 mux in front of a behavioural adder
   logic [N-1:0] fa, fb;
   logic         fcin;
   logic [N:0]   add_res;
   assign add_res = tp.sel ? ({1'b0, tp.a} + {1'b0, tp.b} + {{N{1'b0}}, tp.cin})
                           : ({1'b0, fa} + {1'b0, fb} + {{N{1'b0}}, fcin});
   assign tp.sum  = add_res[N-1:0];
   assign tp.cout = add_res[N];

   int n_checks = 0;
   int n_fail   = 0;
   logic [N:0] misr_model = '0;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         cin;
      logic [N-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [N:0] misr_step(input logic [N:0] m, input logic [N:0] c);
      return {m[N-1:0], m[N]} ^ c;
   endfunction

   function automatic logic [N:0] misr_expect();
`ifdef ADDER_TEST_MISR_EN
      return misr_model;
`else
      return '0;
`endif
   endfunction

   // Runs one full sequence starting at a negedge; abort_k >= 0 pulls reset after cycle abort_k.
   task automatic run_seq(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vcin,
                          input logic [N:0] expc, input bit guard, input int abort_k,
                          input string tag);
      logic [2*N:0]   pat;
      logic [N:0]     got;
      logic [2*N+2:0] cur, hold_obs, apply_exp, apply_obs, so_obs;
      int busy_cnt, done_cnt, done_k;
      pat       = {va, vb, vcin};
      got       = '0;
      hold_obs  = '0;
      so_obs    = '0;
      apply_exp = {1'b0, 1'b1, va, vb, vcin};
      apply_obs = apply_exp;
      busy_cnt  = 0;
      done_cnt  = 0;
      done_k    = -1;
      tp.start  = 1'b1;
      for (int k = 0; k <= BUSY_LEN; k++) begin
         @(negedge clk);
         cur = {tp.scan_out, tp.sel, tp.a, tp.b, tp.cin};
         if (tp.busy) busy_cnt++;
         if (tp.done) begin
            done_cnt++;
            done_k = k;
         end
         if (k <= 2*N) begin
            if (hold_obs == '0) hold_obs = cur;
         end else if (k < SO_START) begin
            if (cur != apply_exp && apply_obs == apply_exp) apply_obs = cur;
         end else if (k < BUSY_LEN) begin
            got[k-SO_START] = tp.scan_out;
            if (so_obs == '0) so_obs = {1'b0, cur[2*N+1:0]};
         end
         if (k == abort_k) begin
            rst_n = 1'b0;
            #1;
            check({tag, " async reset"},
                  {tp.busy, tp.done, tp.sel, tp.scan_out, tp.a, tp.b, tp.cin}, '0);
            tp.start = 1'b0;
            misr_model = '0;
            @(negedge clk);
            rst_n = 1'b1;
            $display("seq %s aborted by reset at cycle %0d", tag, k);
            return;
         end
         tp.start   = guard && (k == 3 || k == 20 || k == 40);
         tp.scan_in = (k <= 2*N) ? pat[k] : 1'($urandom);
         fa   = N'($urandom);
         fb   = N'($urandom);
         fcin = 1'($urandom);
      end
      tp.start = 1'b0;
      check({tag, " hold during shift"}, hold_obs, '0);
      check({tag, " apply drive"}, apply_obs, apply_exp);
      check({tag, " drive released"}, so_obs, '0);
      check({tag, " response"}, got, expc);
      check({tag, " busy length"}, busy_cnt, BUSY_LEN);
      check({tag, " done cycle"}, {done_cnt, done_k}, {32'd1, 32'(BUSY_LEN)});
      misr_model = misr_step(misr_model, expc);
      check({tag, " misr"}, tp.misr_sig, misr_expect());
      $display("seq %s a=%h b=%h cin=%0d resp=%h exp=%h busy=%0d misr=%h",
               tag, va, vb, vcin, got, expc, busy_cnt, tp.misr_sig);
   endtask

   initial begin
      logic [N-1:0] ra, rb;
      logic         rc;
      int           bcnt;
      vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
      vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      vecs[5] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1};

      tp.start = 1'b0;
      tp.scan_in = 1'b0;
      fa = '0; fb = '0; fcin = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("idle after reset",
            {tp.busy, tp.done, tp.sel, tp.scan_out, tp.a, tp.b, tp.cin, tp.misr_sig}, '0);

      // Table vectors, run back-to-back (start asserted in each done cycle)
      for (int i = 0; i < 6; i++)
         run_seq(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].exp_cout, vecs[i].exp_sum},
                 1'b0, -1, $sformatf("vec%0d", i));

      // Busy guard: stray start pulses are ignored, no second sequence follows
      repeat (2) @(negedge clk);
      run_seq(16'h1234, 16'h4321, 1'b1, 17'h05556, 1'b1, -1, "guard");
      bcnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (tp.busy) bcnt++;
      end
      check("guard no requeue", bcnt, 0);

      // Mid-operation resets, then a clean restart
      run_seq(16'hBEEF, 16'h1111, 1'b1, 17'h0D001, 1'b0, 10, "rst_shift");
      run_seq(16'hBEEF, 16'h1111, 1'b1, 17'h0D001, 1'b0, 2*N+1, "rst_apply");
      run_seq(16'hBEEF, 16'h1111, 1'b1, 17'h0D001, 1'b0, -1, "after_rst");

      // MISR from a fresh reset: 10000.. then 00001
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      misr_model = '0;
      @(negedge clk);
      run_seq(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0, -1, "misr1");
`ifdef ADDER_TEST_MISR_EN
      check("misr first capture", tp.misr_sig, 17'h10000);
`else
      check("misr first capture", tp.misr_sig, 17'h00000);
`endif
      run_seq(16'h0000, 16'h0000, 1'b1, 17'h00001, 1'b0, -1, "misr2");
      check("misr second capture", tp.misr_sig, 17'h00000);

      // Random patterns with random idle gaps (gap 0 = back-to-back)
      for (int i = 0; i < 20; i++) begin
         ra = N'($urandom);
         rb = N'($urandom);
         rc = 1'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_seq(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc}, 1'b0, -1,
                 $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
